rr_handshake_arbiter: RTL and testbench
=======================================

// Module: rr_handshake_arbiter
// PURPOSE
//  Shares one downstream req/ack consumer channel (e.g. the left port of a shared
//  async_operator or an out node) among NUM_SRC upstream req/ack producer channels.
//  Sources are served round-robin, one transfer at a time, with a per-source enable mask.
//  A timeout skips silent sources. Each forwarded word carries the index of its source.
//  Sits between dataflow graph nodes and a shared functional unit inside an arf-level netlist.
// PARAMETERS
//  data_width  32  width of every data word
//  num_src     4   number of upstream source channels (>=1)
//  timeout     16  FETCH cycles without src_ack before the source is skipped; 0 = wait forever
//  tag_w       (num_src>1)?$clog2(num_src):1   width of dn_tag
// PORTS
//  clk        in   1               single clock, all logic on posedge
//  rst        in   1               synchronous reset, ACTIVE-LOW (0 = reset)
//  src_en     in   num_src         per-source enable mask, bit i enables source i
//  src_req    out  num_src         request to source i (we act as its consumer)
//  src_ack    in   num_src         one-cycle ack from source i, data valid in the same cycle
//  src_din    in   data_width*num_src  source i data at bits [data_width*(i+1)-1 : data_width*i]
//  dn_req     in   1               downstream request (level)
//  dn_ack     out  1               one-cycle ack to downstream
//  dn_dout    out  data_width      forwarded word, held stable until next dn_ack
//  dn_tag     out  tag_w           index of source that produced dn_dout
//  busy       out  1               high in any state except IDLE
// BEHAVIOUR
//  Protocol, both sides: the consumer holds req high. The producer pulses ack for exactly 1 cycle
//   when it samples req&~ack, and data is valid in the ack cycle. The consumer drops req after the ack.
//  Reset (rst==0 at posedge): src_req=0, dn_ack=0, dn_dout=0, dn_tag=0, busy=0,
//   state=IDLE, rr_ptr=num_src-1 (first grant is source 0), tmo_cnt=0.
//   Reset wins over every other event, including in-flight fetches. A src_ack arriving in the cycle
//   after reset is ignored.
//  FSM states: IDLE, FETCH, DRAIN, ISSUE.
//  IDLE: if dn_req && |src_en, then grant = first enabled index after rr_ptr (cyclic, wraps num_src-1->0).
//   Latch grant, set src_req[grant]=1 and tmo_cnt=0, go to FETCH.
//   If src_en==0 or dn_req==0, stay in IDLE with all src_req low.
//  FETCH: hold src_req[grant]=1 and all other src_req=0. The grant is locked, and src_en changes are
//   ignored until the FSM leaves FETCH.
//   On src_ack[grant]: latch src_din slice into dn_dout and grant into dn_tag, drop src_req, go to ISSUE.
//   Otherwise tmo_cnt++. If timeout!=0 && tmo_cnt==timeout-1, drop src_req and go to DRAIN.
//  DRAIN (1 cycle): if src_ack[grant] arrives in this cycle (the source saw the last req), accept it
//   exactly as in FETCH and go to ISSUE. Otherwise set rr_ptr=grant (skip the source) and go to IDLE.
//  ISSUE: dn_ack=1 for exactly this cycle. Set rr_ptr=grant and go to IDLE.
//   dn_dout/dn_tag keep their values until the next ISSUE.
//  src_ack on a non-granted index, or in IDLE/ISSUE: ignored, no data latched.
//  Latency, zero-wait source: dn_req seen at edge t -> src_req high t+1 -> src_ack t+2 -> dn_ack t+3.
//   Minimum of 4 cycles per word. src_req[grant] is low for at least 1 cycle between transfers.
//  Data passes unmodified. No arithmetic on data. tmo_cnt width is $clog2(timeout+1), and it saturates.
//  num_src==1: rr_ptr and dn_tag are always 0, and the arbiter behaves as a 1-deep relay.
// TESTING
//  T1 reset: hold rst=0 for 3 cycles with dn_req=1 and src_ack=all 1s. Required: all outputs stay 0 and
//   state=IDLE. After rst=1, the first src_req is 4'b0001.
//  T2 round robin: num_src=4, src_en=4'hF, zero-wait producers with bases 0,100,200,300, dn_req held.
//   Required: dn_tag sequence 0,1,2,3,0. dn_dout sequence 0,100,200,300,1. Exactly 1-cycle dn_ack.
//  T3 mask: src_en=4'b1010. Required: only src_req[1] and src_req[3] ever assert. dn_tag alternates 1,3.
//   Set src_en=0 mid-FETCH: the current word still completes, then the FSM idles with no src_req.
//  T4 timeout: timeout=4, source 1 never acks. Required: src_req[1] is high exactly 4 cycles, then
//   DRAIN, then source 2 is granted. Variant: ack arrives in the DRAIN cycle -> word accepted,
//   dn_tag=1.
//  T5 throughput: 5000 words from 4 zero-wait sources, consumer fail_rate 0.
//   Required: counts per source differ by <=1, no lost or duplicated values, one dn_ack per 4 cycles.
//  T6 stray acks: pulse src_ack[2] while source 0 is granted. Required: dn_dout unchanged and
//   dn_tag never 2 for that transfer.

Source files
------------

// File: rtl/rr_handshake_arbiter_if.sv
// rr_handshake_arbiter_if: bundle of upstream source channels and the shared
// downstream channel. master = arbiter side, slave = environment side.
interface rr_handshake_arbiter_if #(
    parameter int data_width = 32,
    parameter int num_src    = 4,
    parameter int tag_w      = (num_src > 1) ? $clog2(num_src) : 1
);
    logic [num_src-1:0]            src_en;
    logic [num_src-1:0]            src_req;
    logic [num_src-1:0]            src_ack;
    logic [data_width*num_src-1:0] src_din;
    logic                          dn_req;
    logic                          dn_ack;
    logic [data_width-1:0]         dn_dout;
    logic [tag_w-1:0]              dn_tag;
    logic                          busy;

    modport master (
        input  src_en, src_ack, src_din, dn_req,
        output src_req, dn_ack, dn_dout, dn_tag, busy
    );

    modport slave (
        output src_en, src_ack, src_din, dn_req,
        input  src_req, dn_ack, dn_dout, dn_tag, busy
    );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: round-robin share of one downstream req/ack consumer
// among num_src upstream req/ack producers, with enable mask and fetch timeout.
// Ports: clk, rst (sync, active-low), bus (rr_handshake_arbiter_if.master):
//   src_en/src_req/src_ack/src_din upstream, dn_req/dn_ack/dn_dout/dn_tag down, busy.
module rr_handshake_arbiter #(
    parameter int data_width = 32,
    parameter int num_src    = 4,
    parameter int timeout    = 16,
    parameter int tag_w      = (num_src > 1) ? $clog2(num_src) : 1
) (
    input logic                    clk,
    input logic                    rst,
    rr_handshake_arbiter_if.master bus
);
    localparam int tmo_w = (timeout > 0) ? $clog2(timeout + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        ISSUE
    } state_t;

    state_t                state_q, state_d;
    logic [tag_w-1:0]      grant_q, grant_d;
    logic [tag_w-1:0]      rr_q, rr_d;
    logic [tag_w-1:0]      tag_q, tag_d;
    logic [tag_w-1:0]      nxt, idx;
    logic [tmo_w-1:0]      tmo_q, tmo_d;
    logic [num_src-1:0]    req_q, req_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [data_width-1:0] slice;
    logic                  hit;
    logic                  found;

    assign hit   = bus.src_ack[grant_q];
    assign slice = data_width'(bus.src_din >> (int'(grant_q) * data_width));

    // First enabled source strictly after rr_ptr, wrapping; rr_ptr itself
    // is visited last so a lone enabled source can be re-granted.
    always_comb begin
        nxt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= num_src; k++) begin
            idx = tag_w'((int'(rr_q) + k) % num_src);
            if (!found && bus.src_en[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= tag_w'(num_src - 1);
            tmo_q   <= '0;
            req_q   <= '0;
            dout_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            dout_q  <= dout_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        req_d   = req_q;
        dout_d  = dout_q;
        tag_d   = tag_q;
        unique case (state_q)
            IDLE: begin
                req_d = '0;
                if (bus.dn_req && |bus.src_en) begin
                    grant_d    = nxt;
                    req_d[nxt] = 1'b1;
                    tmo_d      = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (hit) begin
                    dout_d  = slice;
                    tag_d   = grant_q;
                    req_d   = '0;
                    state_d = ISSUE;
                end else begin
                    if (tmo_q != '1) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (timeout != 0 && tmo_q == tmo_w'(timeout - 1)) begin
                        req_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The source may have answered the final request cycle.
                if (hit) begin
                    dout_d  = slice;
                    tag_d   = grant_q;
                    state_d = ISSUE;
                end else begin
                    rr_d    = grant_q;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                rr_d    = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.src_req = req_q;
    assign bus.dn_ack  = (state_q == ISSUE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.dn_dout = dout_q;
    assign bus.dn_tag  = tag_q;
endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// tb_rr_handshake_arbiter: randomized and directed bench for the
// round-robin handshake arbiter against a transfer-level reference model.
module tb_rr_handshake_arbiter;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 4;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_handshake_arbiter_if #(.data_width(DW), .num_src(NS), .tag_w(TW)) bus ();

    rr_handshake_arbiter #(
        .data_width(DW), .num_src(NS), .timeout(TO), .tag_w(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                         tag, got, exp, $time);
        end
    endtask

    // stimulus state (applied just after the next rising edge)
    logic          nx_rst, nx_force, nx_dn_req, stray_on;
    logic [NS-1:0] nx_en, nack, stray;
    int            stray_pick;
    int            dly[NS], seen[NS], p_n[NS];
    logic [DW-1:0] din[NS];

    // transfer-level model
    bit            m_active, m_acc;
    int            m_k, m_rem, m_reqc, m_g, m_ptr;
    int            m_n[NS];
    logic          e_busy, e_ack;
    logic [NS-1:0] e_req;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_dout;

    // statistics
    int phase, cyc, any_acks, acks5, last_ack_cyc, t2_idx, t4_runs, t45_tag1;
    int ack_cnt[NS], run_len[NS];
    int t2_tag[5]  = '{0, 1, 2, 3, 0};
    int t2_dout[5] = '{0, 100, 200, 300, 1};

    function automatic int next_src(input logic [NS-1:0] en, input int ptr);
        for (int k = 1; k <= NS; k++)
            if (en[(ptr + k) % NS]) return (ptr + k) % NS;
        return ptr;
    endfunction

    task automatic observe();
        check("busy", bus.busy, e_busy);
        check("src_req", bus.src_req, e_req);
        check("dn_ack", bus.dn_ack, e_ack);
        check("dn_tag", bus.dn_tag, e_tag);
        check("dn_dout", bus.dn_dout, e_dout);
        if (phase == 3) check("t3_mask", bus.src_req & 4'b0101, 0);
        for (int i = 0; i < NS; i++) begin
            if (bus.src_req[i] === 1'b1) begin
                run_len[i]++;
            end else begin
                if (run_len[i] > 0 && phase == 4 && i == 1) begin
                    check("t4_req1_len", run_len[i], TO);
                    t4_runs++;
                end
                run_len[i] = 0;
            end
        end
        if (bus.dn_ack === 1'b1) begin
            any_acks++;
            if (phase == 2 && t2_idx < 5) begin
                check("t2_tag", bus.dn_tag, t2_tag[t2_idx]);
                check("t2_dout", bus.dn_dout, t2_dout[t2_idx]);
                t2_idx++;
            end
            if (phase == 45 && bus.dn_tag == 1) t45_tag1++;
            if (phase == 5) begin
                ack_cnt[bus.dn_tag]++;
                if (last_ack_cyc >= 0) check("t5_gap", cyc - last_ack_cyc, 4);
                last_ack_cyc = cyc;
                acks5++;
            end
            if (phase == 6) check("t6_tag", bus.dn_tag, 0);
        end
    endtask

    // Advance model and producers across the coming rising edge.
    task automatic step();
        int d, j;
        if (!nx_rst_applied()) begin
            m_active = 0;
            m_ptr    = NS - 1;
            e_busy   = 0;
            e_ack    = 0;
            e_req    = '0;
            e_tag    = '0;
            e_dout   = '0;
            for (int i = 0; i < NS; i++) m_n[i] = p_n[i];
        end else begin
            if (!m_active) begin
                if (bus.dn_req && bus.src_en != '0) begin
                    m_g      = next_src(bus.src_en, m_ptr);
                    m_ptr    = m_g;
                    d        = dly[m_g];
                    m_acc    = (d + 1 <= TO);
                    m_reqc   = (d + 2 < TO) ? d + 2 : TO;
                    m_rem    = m_acc ? ((d + 2 <= TO) ? d + 3 : TO + 2) : TO + 1;
                    m_k      = 1;
                    m_active = 1;
                end
            end else begin
                m_k++;
                if (m_k > m_rem) m_active = 0;
            end
            e_busy = m_active;
            e_req  = (m_active && m_k <= m_reqc) ? NS'(1 << m_g) : '0;
            e_ack  = m_active && m_acc && m_k == m_rem;
            if (e_ack) begin
                e_tag  = TW'(m_g);
                e_dout = DW'(m_g * 100 + m_n[m_g]);
                m_n[m_g]++;
            end
        end
        nack  = '0;
        stray = '0;
        for (int i = 0; i < NS; i++) begin
            if (!rst) begin
                seen[i] = 0;
            end else if (bus.src_req[i] && !bus.src_ack[i]) begin
                seen[i]++;
                if (seen[i] == dly[i] + 1) begin
                    nack[i] = 1'b1;
                    din[i]  = DW'(i * 100 + p_n[i]);
                    p_n[i]++;
                    seen[i] = 0;
                end
            end else if (!bus.src_req[i]) begin
                seen[i] = 0;
            end
        end
        if (stray_on && rst && $urandom_range(0, 2) == 0) begin
            j = (stray_pick >= 0) ? stray_pick : int'($urandom_range(0, NS - 1));
            if (!(m_active && j == m_g) && !nack[j]) begin
                stray[j] = 1'b1;
                din[j]   = 32'hBAD0_0000 | DW'(j);
            end
        end
    endtask

    function automatic logic nx_rst_applied();
        return rst;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        rst        = nx_rst;
        bus.dn_req = nx_dn_req;
        bus.src_en = nx_en;
        bus.src_ack = nx_force ? '1 : (nack | stray);
        for (int i = 0; i < NS; i++) bus.src_din[i*DW +: DW] = din[i];
        @(negedge clk);
        cyc++;
        observe();
        step();
    endtask

    task automatic quiesce();
        phase     = 0;
        stray_on  = 0;
        nx_dn_req = 0;
        repeat (10) cycle();
    endtask

    initial begin
        int  a0, mx, mn, guard;
        bit  found;
        for (int i = 0; i < NS; i++) begin
            dly[i] = 0; seen[i] = 0; p_n[i] = 0; m_n[i] = 0;
            din[i] = '0; ack_cnt[i] = 0; run_len[i] = 0;
        end
        rst = 1'b0;
        bus.src_en = 4'hF; bus.src_ack = '1; bus.dn_req = 1'b1; bus.src_din = '0;
        nx_rst = 0; nx_force = 1; nx_en = 4'hF; nx_dn_req = 1;
        stray_on = 0; stray_pick = -1; nack = '0; stray = '0;
        m_active = 0; m_ptr = NS - 1; m_k = 0; m_rem = 0; m_reqc = 0; m_g = 0; m_acc = 0;
        e_busy = 0; e_ack = 0; e_req = '0; e_tag = '0; e_dout = '0;
        phase = 1; cyc = 0; any_acks = 0; acks5 = 0; last_ack_cyc = -1;
        t2_idx = 0; t4_runs = 0; t45_tag1 = 0;

        // T1: reset with dn_req and every src_ack held high
        repeat (3) begin
            cycle();
            check("t1_outs", {bus.busy, bus.dn_ack, bus.src_req,
                              bus.dn_tag, bus.dn_dout}, '0);
        end
        nx_rst = 1; phase = 2;
        cycle();
        nx_force = 0;
        cycle();
        check("t1_first_req", bus.src_req, 4'b0001);

        // T2: zero-wait round robin
        repeat (25) cycle();
        check("t2_words", t2_idx, 5);

        // T3: mask, then disable everything mid-fetch
        quiesce();
        phase = 3; nx_en = 4'b1010; nx_dn_req = 1;
        repeat (40) cycle();
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
            cycle();
            if (bus.src_req != '0) found = 1;
        end
        check("t3_got_req", found, 1);
        a0 = any_acks;
        nx_en = '0;
        repeat (12) cycle();
        check("t3_last_word", any_acks - a0, 1);
        check("t3_idle_req", bus.src_req, 0);
        check("t3_idle_busy", bus.busy, 0);

        // T4: silent source 1 times out; variant answers in the drain cycle
        quiesce();
        dly[1] = TO + 6; nx_en = 4'hF; phase = 4; nx_dn_req = 1;
        repeat (40) cycle();
        check("t4_runs_seen", t4_runs > 0, 1);
        quiesce();
        dly[1] = TO - 1; phase = 45; nx_dn_req = 1;
        repeat (30) cycle();
        check("t4v_tag1_words", t45_tag1 > 0, 1);

        // T5: throughput and fairness
        quiesce();
        for (int i = 0; i < NS; i++) dly[i] = 0;
        phase = 5; nx_dn_req = 1; nx_en = 4'hF;
        guard = 0;
        while (acks5 < 5000 && guard < 21000) begin
            cycle();
            guard++;
        end
        check("t5_words", acks5, 5000);
        mx = ack_cnt[0]; mn = ack_cnt[0];
        for (int i = 1; i < NS; i++) begin
            if (ack_cnt[i] > mx) mx = ack_cnt[i];
            if (ack_cnt[i] < mn) mn = ack_cnt[i];
        end
        check("t5_fair", (mx - mn) <= 1, 1);

        // T6: stray acks on source 2 while source 0 is served
        quiesce();
        dly[0] = 2; nx_en = 4'b0001; phase = 6; nx_dn_req = 1;
        stray_on = 1; stray_pick = 2;
        repeat (60) cycle();
        stray_pick = -1;

        // Random traffic: masks, delays, stray acks, in-flight resets
        for (int b = 0; b < 10; b++) begin
            quiesce();
            for (int i = 0; i < NS; i++) dly[i] = $urandom_range(0, TO + 1);
            phase = 7; stray_on = 1;
            repeat (200) begin
                if ($urandom_range(0, 9) == 0) nx_en = NS'($urandom_range(0, 15));
                nx_dn_req = ($urandom_range(0, 9) != 0);
                nx_rst    = ($urandom_range(0, 149) != 0);
                cycle();
            end
            nx_rst = 1;
        end
        quiesce();
        check("end_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
